// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC start/stop pulse sequencer.
package tdc_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4
    } tdc_state_e;

endpackage

// File: rtl/tdc_stop_timer.sv
// Per-channel stop timer: down-counter loaded on the start cycle, one-cycle fire at terminal count.
module tdc_stop_timer
    import tdc_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          CLK12MHZ,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          load,
    input  logic [DW-1:0] value,
    output logic          fire,
    output logic          fired
);

    logic [DW-1:0] cnt;
    logic [DW-1:0] eff;

    assign eff = (value == '0) ? DW'(1) : value;

    // An idle timer reports fired so it can never count on its own.
    always_ff @(posedge CLK12MHZ or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            fire  <= 1'b0;
            fired <= 1'b1;
        end else if (clr) begin
            cnt   <= '0;
            fire  <= 1'b0;
            fired <= 1'b1;
        end else if (load) begin
            cnt   <= eff - DW'(1);
            fire  <= (eff == DW'(1));
            fired <= (eff == DW'(1));
        end else begin
            fire <= 1'b0;
            if (!fired && cnt != '0) begin
                cnt <= cnt - DW'(1);
                if (cnt == DW'(1)) begin
                    fire  <= 1'b1;
                    fired <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/tdc_pulse_seq.sv
// Button-launched burst sequencer of common start / per-channel stop strobes for TDC test.
//   state | meaning
//   IDLE  | waiting for debounced press; busy low
//   START | start strobe high, stop timers load at end of cycle
//   WAIT  | timers running, stops fire; leave once all fired
//   GAP   | latched gap idle cycles before the next start
//   DONE  | done strobe for one cycle, then IDLE
module tdc_pulse_seq
    import tdc_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int DW        = 8,
    parameter int GW        = 8,
    parameter int BW        = 8,
    parameter int DB_CYCLES = 1024
) (
    input  logic              CLK12MHZ,
    input  logic              rst_n,
    input  logic              en,
    input  logic              button,
    input  logic [NCH*DW-1:0] delay,
    input  logic [GW-1:0]     gap,
    input  logic [BW-1:0]     burst_len,
    output logic              start,
    output logic [NCH-1:0]    stop,
    output logic              busy,
    output logic              done,
    output logic [BW-1:0]     pair_cnt
);

    localparam int DBCW = $clog2(DB_CYCLES + 1);

    logic            btn_s1;
    logic            btn_s2;
    logic [DBCW-1:0] db_cnt;
    logic            trig;

    // Counter saturates at DB_CYCLES so a held button yields a single trigger.
    always_ff @(posedge CLK12MHZ or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
            db_cnt <= '0;
            trig   <= 1'b0;
        end else begin
            btn_s1 <= button;
            btn_s2 <= btn_s1;
            trig   <= btn_s2 && (db_cnt == DBCW'(DB_CYCLES - 1));
            if (!btn_s2) begin
                db_cnt <= '0;
            end else if (db_cnt != DBCW'(DB_CYCLES)) begin
                db_cnt <= db_cnt + DBCW'(1);
            end
        end
    end

    tdc_state_e        state;
    logic [NCH*DW-1:0] delay_q;
    logic [GW-1:0]     gap_q;
    logic [GW-1:0]     gap_cnt;
    logic [BW-1:0]     len_q;
    logic [NCH-1:0]    fire;
    logic [NCH-1:0]    fired;
    logic              tmr_load;
    logic              tmr_clr;
    logic              all_fired;

    assign tmr_load  = (state == START);
    assign tmr_clr   = ~en;
    assign all_fired = &fired;
    assign stop      = fire;

    for (genvar k = 0; k < NCH; k++) begin : g_tmr
        tdc_stop_timer #(.DW(DW)) u_tmr (
            .CLK12MHZ (CLK12MHZ),
            .rst_n    (rst_n),
            .clr      (tmr_clr),
            .load     (tmr_load),
            .value    (delay_q[k*DW +: DW]),
            .fire     (fire[k]),
            .fired    (fired[k])
        );
    end

    always_ff @(posedge CLK12MHZ or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            start    <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            pair_cnt <= '0;
            delay_q  <= '0;
            gap_q    <= '0;
            gap_cnt  <= '0;
            len_q    <= '0;
        end else if (!en) begin
            state <= IDLE;
            start <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            start <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (trig && burst_len != '0) begin
                        delay_q  <= delay;
                        gap_q    <= gap;
                        len_q    <= burst_len;
                        pair_cnt <= BW'(1);
                        start    <= 1'b1;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: state <= WAIT;
                WAIT: begin
                    // The final pair finishes straight into DONE without a trailing gap.
                    if (all_fired) begin
                        if (pair_cnt >= len_q) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (gap_q == '0) begin
                            start    <= 1'b1;
                            pair_cnt <= pair_cnt + BW'(1);
                            state    <= START;
                        end else begin
                            gap_cnt <= gap_q;
                            state   <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GW'(1)) begin
                        if (pair_cnt < len_q) begin
                            start    <= 1'b1;
                            pair_cnt <= pair_cnt + BW'(1);
                            state    <= START;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_pulse_seq.sv
// Directed plus randomized bench for tdc_pulse_seq against an event-schedule reference model.
module tb_tdc_pulse_seq;

    localparam int NCH  = 4;
    localparam int DW   = 8;
    localparam int GW   = 8;
    localparam int BW   = 8;
    localparam int DB   = 8;
    localparam int MAXC = 512;
    localparam int OW   = 1 + NCH + 1 + 1 + BW;

    logic              CLK12MHZ = 1'b0;
    logic              rst_n;
    logic              en;
    logic              button;
    logic [NCH*DW-1:0] delay;
    logic [GW-1:0]     gap;
    logic [BW-1:0]     burst_len;
    logic              start;
    logic [NCH-1:0]    stop;
    logic              busy;
    logic              done;
    logic [BW-1:0]     pair_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    logic           exp_start [MAXC];
    logic [NCH-1:0] exp_stop  [MAXC];
    logic           exp_done  [MAXC];
    logic           exp_busy  [MAXC];
    logic [BW-1:0]  exp_pc    [MAXC];
    int             model_len;
    logic [BW-1:0]  last_pc = '0;

    logic [NCH*DW-1:0] rnd_d;
    int                rnd_g;
    int                rnd_bl;

    tdc_pulse_seq #(
        .NCH(NCH), .DW(DW), .GW(GW), .BW(BW), .DB_CYCLES(DB)
    ) dut (
        .CLK12MHZ  (CLK12MHZ),
        .rst_n     (rst_n),
        .en        (en),
        .button    (button),
        .delay     (delay),
        .gap       (gap),
        .burst_len (burst_len),
        .start     (start),
        .stop      (stop),
        .busy      (busy),
        .done      (done),
        .pair_cnt  (pair_cnt)
    );

    always #5 CLK12MHZ = ~CLK12MHZ;

    function automatic logic [OW-1:0] obs();
        return {start, stop, done, busy, pair_cnt};
    endfunction

    task automatic chk(input logic [OW-1:0] o, input logic [OW-1:0] e, input string tag, input int cyc);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed={st,stop,dn,bsy,pc}=%h expected=%h", tag, cyc, o, e);
        end
    endtask

    task automatic chk_int(input int o, input int e, input string tag);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    // Expected schedule per cycle offset from the first start of a burst.
    task automatic build_model(input logic [NCH*DW-1:0] d, input int g, input int bl, input int abort_at);
        int dk[NCH];
        int dm, s, done_at, pc;
        dm = 1;
        for (int k = 0; k < NCH; k++) begin
            dk[k] = int'(d[k*DW +: DW]);
            if (dk[k] == 0) dk[k] = 1;
            if (dk[k] > dm) dm = dk[k];
        end
        for (int c = 0; c < MAXC; c++) begin
            exp_start[c] = 1'b0;
            exp_stop[c]  = '0;
            exp_done[c]  = 1'b0;
            exp_busy[c]  = 1'b0;
        end
        s = 0;
        for (int p = 0; p < bl; p++) begin
            exp_start[s] = 1'b1;
            for (int k = 0; k < NCH; k++) exp_stop[s + dk[k]][k] = 1'b1;
            if (p < bl - 1) s = s + dm + 1 + g;
        end
        done_at = s + dm + 1;
        exp_done[done_at] = 1'b1;
        pc = 0;
        for (int c = 0; c < MAXC; c++) begin
            if (c <= done_at) exp_busy[c] = 1'b1;
            if (exp_start[c]) pc++;
            exp_pc[c] = BW'(pc);
        end
        model_len = done_at + 1;
        if (abort_at >= 0 && abort_at < done_at) begin
            for (int c = abort_at + 1; c < MAXC; c++) begin
                exp_start[c] = 1'b0;
                exp_stop[c]  = '0;
                exp_done[c]  = 1'b0;
                exp_busy[c]  = 1'b0;
                exp_pc[c]    = exp_pc[abort_at];
            end
            model_len = abort_at + 1;
        end
    endtask

    task automatic check_idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            chk(obs(), {1'b0, {NCH{1'b0}}, 1'b0, 1'b0, last_pc}, tag, i);
            @(negedge CLK12MHZ);
        end
    endtask

    // Press (held until start when hold==0, else released after hold cycles) and time the start.
    task automatic press_and_wait(input int hold, input string tag);
        int lat;
        bit found;
        lat = 0;
        found = 1'b0;
        button = 1'b1;
        for (int j = 1; j <= 60 && !found; j++) begin
            @(negedge CLK12MHZ);
            if (start) begin
                found = 1'b1;
                lat = j;
            end
            if (hold != 0 && j == hold) button = 1'b0;
        end
        chk_int(lat, DB + 3, tag);
    endtask

    task automatic new_burst(input logic [NCH*DW-1:0] d, input int g, input int bl,
                             input int hold, input int abort_at, input string tag);
        delay = d;
        gap = GW'(g);
        burst_len = BW'(bl);
        en = 1'b1;
        button = 1'b0;
        check_idle(4, {tag, "_pre"});
        build_model(d, g, bl, abort_at);
        press_and_wait(hold, {tag, "_lat"});
    endtask

    task automatic run_check(input int extra, input int press_at, input int press_len,
                             input int abort_at, input bit mutate, input string tag);
        int ncyc;
        ncyc = model_len + extra;
        for (int i = 0; i < ncyc; i++) begin
            chk(obs(), {exp_start[i], exp_stop[i], exp_done[i], exp_busy[i], exp_pc[i]}, tag, i);
            button = (i >= press_at) && (i < press_at + press_len);
            if (i == abort_at) en = 1'b0;
            if (mutate) begin
                delay = $urandom;
                gap = GW'($urandom);
                burst_len = BW'($urandom);
            end
            @(negedge CLK12MHZ);
        end
        last_pc = exp_pc[ncyc-1];
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b1;
        button = 1'b0;
        delay = '0;
        gap = '0;
        burst_len = BW'(1);

        // Reset holds everything at zero even with a busy button.
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK12MHZ);
            button = ~button;
            chk(obs(), '0, "reset", i);
        end
        button = 1'b0;
        rst_n = 1'b1;
        check_idle(4, "post_reset");

        // Short glitches and a hold one cycle too short must not trigger.
        for (int gl = 0; gl < 3; gl++) begin
            button = 1'b1;
            check_idle(3, "glitch_hi");
            button = 1'b0;
            check_idle(2, "glitch_lo");
        end
        button = 1'b1;
        check_idle(DB - 1, "short_hold");
        button = 1'b0;
        check_idle(15, "short_hold_after");

        // Exactly DB cycles of press gives one start.
        new_burst({NCH{8'd1}}, 0, 1, DB, -1, "db_exact");
        run_check(15, 0, 0, -1, 1'b0, "db_exact");

        // Single pair with mixed delays; button stays held, no second start.
        new_burst({8'd4, 8'd3, 8'd0, 8'd7}, 9, 1, 0, -1, "single");
        run_check(12, 0, 40, -1, 1'b0, "single");

        // Three-pair burst with a second press landing mid-burst.
        new_burst({NCH{8'd2}}, 5, 3, 0, -1, "burst3");
        run_check(20, 1, 12, -1, 1'b0, "burst3");

        // Abort in WAIT, then a fresh burst.
        new_burst({8'd9, 8'd10, 8'd11, 8'd12}, 3, 2, 0, 5, "abort");
        run_check(16, 0, 0, 5, 1'b0, "abort");
        new_burst({8'd9, 8'd10, 8'd11, 8'd12}, 3, 2, 0, -1, "retrig");
        run_check(6, 0, 0, -1, 1'b0, "retrig");

        // burst_len of zero ignores the trigger.
        burst_len = '0;
        button = 1'b1;
        check_idle(25, "len0");
        button = 1'b0;
        check_idle(4, "len0_after");

        // Back-to-back pairs with zero gap.
        new_burst({NCH{8'd1}}, 0, 4, 0, -1, "gap0");
        run_check(6, 0, 0, -1, 1'b0, "gap0");

        // Randomized bursts while the inputs churn underneath.
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < NCH; k++) rnd_d[k*DW +: DW] = DW'($urandom_range(0, 12));
            rnd_g  = $urandom_range(0, 6);
            rnd_bl = $urandom_range(1, 4);
            new_burst(rnd_d, rnd_g, rnd_bl, 0, -1, "rand");
            run_check(6, 0, 0, -1, 1'b1, "rand");
        end

        // Asynchronous reset mid-burst.
        new_burst({NCH{8'd6}}, 2, 3, 0, -1, "rst_mid");
        button = 1'b0;
        repeat (3) @(negedge CLK12MHZ);
        rst_n = 1'b0;
        #1;
        chk(obs(), '0, "rst_async", 0);
        @(negedge CLK12MHZ);
        chk(obs(), '0, "rst_hold", 1);
        rst_n = 1'b1;
        last_pc = '0;
        check_idle(20, "rst_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
